// File: rtl/led_mux_scheduler_if.sv
// led_mux_scheduler_if
// Groups the brightness write port, scan enable and LED outputs of the
// multiplexed RGB LED scan controller.
//   enable     : run scanning while high
//   wr_en      : single-cycle brightness write strobe
//   wr_addr    : LED index = row*N_COLS + col
//   wr_data    : brightness value
//   led_a      : column drive, active-high
//   led_b      : row select, one-hot active-high
//   frame_done : one-cycle pulse at the end of each frame
//   busy       : high whenever the scanner is not idle
// master = the controlling side (top level / bench), slave = the scanner.
interface led_mux_scheduler_if #(
    parameter int unsigned N_COLS    = 7,
    parameter int unsigned N_ROWS    = 3,
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned ADDR_BITS = 5
);
    logic                 enable;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [PWM_BITS-1:0]  wr_data;
    logic [N_COLS-1:0]    led_a;
    logic [N_ROWS-1:0]    led_b;
    logic                 frame_done;
    logic                 busy;

    modport master (
        output enable, wr_en, wr_addr, wr_data,
        input  led_a, led_b, frame_done, busy
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data,
        output led_a, led_b, frame_done, busy
    );
endinterface

// File: rtl/led_mux_scheduler.sv
// led_mux_scheduler
// Scan controller for a multiplexed N_ROWS x N_COLS LED array. A shadow
// brightness table is written through the bus write port; an active copy is
// loaded from it at every frame boundary (and when scanning starts) so a
// frame never shows a half-updated table. Each row is lit for 2^PWM_BITS
// PWM ticks of PRESCALE clocks, followed by BLANK_CYCLES dark clocks.
// Ports:
//   clk30 : system clock
//   rst   : asynchronous, active-high reset
//   bus   : led_mux_scheduler_if.slave (enable, write port, led_a/led_b,
//           frame_done, busy)
module led_mux_scheduler #(
    parameter int unsigned N_COLS       = 7,
    parameter int unsigned N_ROWS       = 3,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PRESCALE     = 16,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic                 clk30,
    input  logic                 rst,
    led_mux_scheduler_if.slave   bus
);

    localparam int unsigned N_LEDS     = N_COLS * N_ROWS;
    localparam int unsigned ADDR_BITS  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int unsigned ROW_BITS   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned TICK_BITS  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BLANK_BITS = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [ROW_BITS-1:0]   ROW_LAST   = ROW_BITS'(N_ROWS - 1);
    localparam logic [TICK_BITS-1:0]  TICK_LAST  = TICK_BITS'(PRESCALE - 1);
    localparam logic [BLANK_BITS-1:0] BLANK_LAST = BLANK_BITS'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StBlank
    } state_e;

    state_e                state_q, state_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [TICK_BITS-1:0]  tick_q, tick_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [BLANK_BITS-1:0] blank_q, blank_d;
    logic                  swap;
    logic                  frame_end;

    logic [PWM_BITS-1:0]   shadow_q [N_LEDS];
    logic [PWM_BITS-1:0]   active_q [N_LEDS];
    logic                  wr_ok;

    logic [N_COLS-1:0]     led_a_q, led_a_d;
    logic [N_ROWS-1:0]     led_b_q, led_b_d;
    logic                  frame_done_q;

    // ------------------------------------------------------------------
    // FSM state and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            tick_q  <= '0;
            pwm_q   <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            blank_q <= blank_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        tick_d    = tick_q;
        pwm_d     = pwm_q;
        blank_d   = blank_q;
        swap      = 1'b0;
        frame_end = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StScan;
                    row_d   = '0;
                    tick_d  = '0;
                    pwm_d   = '0;
                    swap    = 1'b1;
                end
            end

            StScan: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    pwm_d  = pwm_q + 1'b1;
                    // Last PWM tick of the row: the counter wraps to 0 here.
                    if (pwm_q == '1) begin
                        state_d = StBlank;
                        blank_d = '0;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            StBlank: begin
                if (blank_q == BLANK_LAST) begin
                    blank_d = '0;
                    if (row_q != ROW_LAST) begin
                        row_d   = row_q + 1'b1;
                        state_d = StScan;
                    end else begin
                        // Frame boundary: the only point where enable is honoured
                        // and where the next frame's table is latched.
                        frame_end = 1'b1;
                        swap      = 1'b1;
                        row_d     = '0;
                        state_d   = bus.enable ? StScan : StIdle;
                    end
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Brightness tables
    // ------------------------------------------------------------------
    // Out-of-range indices are dropped rather than aliased onto real LEDs.
    assign wr_ok = (32'(bus.wr_addr) < N_LEDS);

    // Non-blocking semantics make the swap copy shadow's pre-write contents,
    // so a write in the swap cycle only reaches the next frame.
    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LEDS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (swap) begin
                for (int i = 0; i < N_LEDS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (bus.wr_en && wr_ok) begin
                shadow_q[bus.wr_addr[ADDR_BITS-1:0]] <= bus.wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, registered one cycle behind the state
    // ------------------------------------------------------------------
    always_comb begin
        logic [ADDR_BITS-1:0] idx;
        idx     = '0;
        led_a_d = '0;
        led_b_d = '0;
        if (state_q == StScan) begin
            led_b_d[row_q] = 1'b1;
            for (int c = 0; c < N_COLS; c++) begin
                idx        = ADDR_BITS'(int'(row_q) * N_COLS + c);
                // Strict compare: 0 is always dark, full-scale is never fully on.
                led_a_d[c] = (pwm_q < active_q[idx]);
            end
        end
    end

    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            led_a_q      <= '0;
            led_b_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            led_a_q      <= led_a_d;
            led_b_q      <= led_b_d;
            frame_done_q <= frame_end;
        end
    end

    assign bus.led_a      = led_a_q;
    assign bus.led_b      = led_b_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_led_mux_scheduler.sv
// tb_led_mux_scheduler
// Scoreboarded bench for led_mux_scheduler with PRESCALE=1, BLANK_CYCLES=4
// (256 lit cycles + 4 dark cycles per row, 780 cycles per frame). The
// stimulus keeps a model of the shadow/active tables and pushes the expected
// per-row on-counts of every frame it starts; the monitor measures each lit
// row window on the outputs and compares it against the queue head.
module tb_led_mux_scheduler;

    localparam int ROW_LEN = 256;
    localparam int GAP     = 4;
    localparam int FRAME   = 780;
    localparam int N_LEDS  = 21;

    typedef struct packed {
        logic [2:0]      rsel;
        logic [6:0][8:0] cnt;
    } row_exp_t;

    logic clk30 = 1'b0;
    logic rst   = 1'b1;

    always #5 clk30 = ~clk30;

    led_mux_scheduler_if #(
        .N_COLS    (7),
        .N_ROWS    (3),
        .PWM_BITS  (8),
        .ADDR_BITS (5)
    ) bus ();

    led_mux_scheduler #(
        .N_COLS       (7),
        .N_ROWS       (3),
        .PWM_BITS     (8),
        .PRESCALE     (1),
        .BLANK_CYCLES (4)
    ) dut (
        .clk30 (clk30),
        .rst   (rst),
        .bus   (bus)
    );

    row_exp_t   exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] shadow_m [N_LEDS];
    logic [7:0] active_m [N_LEDS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_note(input string name);
        n_total++;
        $display("FAIL %s: got nothing, expected an event", name);
    endtask

    // ---------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------
    int              cyc       = 0;
    logic            in_win    = 1'b0;
    logic [2:0]      win_rsel  = '0;
    logic [6:0][8:0] win_cnt   = '0;
    int              win_len   = 0;
    int              dark      = 0;
    logic            have_prev = 1'b0;
    logic            have_fd   = 1'b0;
    int              last_fd   = 0;
    logic            fd_prev   = 1'b0;
    int              inv_err   = 0;

    always @(negedge clk30) begin
        row_exp_t e;
        cyc++;
        if (rst) begin
            in_win    = 1'b0;
            have_prev = 1'b0;
            have_fd   = 1'b0;
            fd_prev   = 1'b0;
            dark      = 0;
        end else begin
            if (!$onehot0(bus.led_b)) inv_err++;
            if (bus.led_b == '0 && bus.led_a != '0) inv_err++;
            if (bus.frame_done && fd_prev) inv_err++;
            fd_prev = bus.frame_done;
            if (bus.frame_done) begin
                if (have_fd) check("frame_period", 64'(cyc - last_fd), 64'(FRAME));
                have_fd = 1'b1;
                last_fd = cyc;
            end
            if (bus.led_b != '0) begin
                if (!in_win) begin
                    if (have_prev) check("row_gap", 64'(dark), 64'(GAP));
                    in_win   = 1'b1;
                    win_rsel = bus.led_b;
                    win_cnt  = '0;
                    win_len  = 0;
                end
                if (bus.led_b != win_rsel) inv_err++;
                win_len++;
                for (int c = 0; c < 7; c++) win_cnt[c] = win_cnt[c] + 9'(bus.led_a[c]);
            end else if (in_win) begin
                in_win    = 1'b0;
                have_prev = 1'b1;
                dark      = 1;
                if (exp_q.size() == 0) begin
                    fail_note("row_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("row_select", 64'(win_rsel), 64'(e.rsel));
                    check("row_length", 64'(win_len), 64'(ROW_LEN));
                    check("row_on_counts", 64'(win_cnt), 64'(e.cnt));
                end
            end else begin
                dark++;
            end
            if (!bus.busy) begin
                have_prev = 1'b0;
                have_fd   = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers (all driving happens 1 unit after a rising edge)
    // ---------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk30);
            #1;
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(addr);
        bus.wr_data = data;
        cycles(1);
        bus.wr_en   = 1'b0;
        if (addr < N_LEDS) shadow_m[addr] = data;
    endtask

    task automatic swap_model();
        for (int i = 0; i < N_LEDS; i++) active_m[i] = shadow_m[i];
    endtask

    task automatic push_frame();
        row_exp_t e;
        for (int r = 0; r < 3; r++) begin
            e.rsel = 3'(1 << r);
            for (int c = 0; c < 7; c++) e.cnt[c] = 9'(active_m[r * 7 + c]);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_fd(input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycles(1);
            if (bus.frame_done) seen = 1'b1;
        end
        if (!seen) fail_note(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------
    initial begin
        int pulses;
        bus.enable  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end

        // Reset state
        #12;
        check("reset_led_a", 64'(bus.led_a), 64'(0));
        check("reset_led_b", 64'(bus.led_b), 64'(0));
        check("reset_frame_done", 64'(bus.frame_done), 64'(0));
        check("reset_busy", 64'(bus.busy), 64'(0));
        @(posedge clk30);
        #1;
        rst = 1'b0;
        cycles(20);
        check("idle_busy", 64'(bus.busy), 64'(0));

        // Frame 1: single LED (row 1, col 2) = 0x40
        wr(9, 8'h40);
        swap_model();
        push_frame();
        bus.enable = 1'b1;
        cycles(100);
        // Extremes and invalid addresses, visible from frame 2
        wr(0, 8'h00);
        wr(6, 8'hFF);
        wr(21, 8'hFF);
        wr(31, 8'hFF);
        wait_fd(1000, "frame1_done");
        swap_model();
        push_frame();
        // Write in the frame_done cycle: frame 3, not frame 2
        wr(13, 8'h10);
        // Mid-frame write during row 1 of frame 2
        cycles(300);
        wr(0, 8'h80);
        wait_fd(1000, "frame2_done");
        swap_model();
        push_frame();

        // Drop enable during row 0 of frame 3: frame still completes
        cycles(50);
        bus.enable = 1'b0;
        wait_fd(1000, "frame3_done");
        pulses = 0;
        for (int i = 0; i < 800; i++) begin
            cycles(1);
            if (bus.frame_done) pulses++;
        end
        check("frame_done_after_drop", 64'(pulses), 64'(0));
        check("busy_after_drop", 64'(bus.busy), 64'(0));

        // Asynchronous reset mid-scan while LEDs are lit
        bus.enable = 1'b1;
        cycles(100);
        check("led_a_lit_before_reset", 64'(bus.led_a != '0), 64'(1));
        #2;
        rst        = 1'b1;
        bus.enable = 1'b0;
        #1;
        check("async_reset_led_a", 64'(bus.led_a), 64'(0));
        check("async_reset_led_b", 64'(bus.led_b), 64'(0));
        check("async_reset_busy", 64'(bus.busy), 64'(0));
        @(posedge clk30);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N_LEDS; i++) shadow_m[i] = '0;
        cycles(30);
        check("post_reset_busy", 64'(bus.busy), 64'(0));
        check("post_reset_led_b", 64'(bus.led_b), 64'(0));

        // Tables must have been cleared by the reset: an all-dark frame
        swap_model();
        push_frame();
        bus.enable = 1'b1;
        cycles(10);
        bus.enable = 1'b0;
        wait_fd(1000, "frame_after_reset_done");
        cycles(10);
        check("final_busy", 64'(bus.busy), 64'(0));
        check("rows_pending", 64'(exp_q.size()), 64'(0));
        check("output_invariants", 64'(inv_err), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
